// File: rtl/program_loader.sv
// program_loader: write-side loader for the byte-wide program memory.
// Receives a frame {LEN, N payload bytes, CHK} over a 4-phase valid/ack handshake.
// Payload is written to addresses 0..N-1 and checked against an XOR checksum.
// The core stays stalled while loading_o is high.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous, active-high reset
//   load_start_i  one-cycle pulse that starts (or restarts) a load session
//   byte_in_i     host data, stable while byte_valid_i is high
//   byte_valid_i  host strobe, asynchronous to clk_i
//   byte_ack_o    loader acknowledge (4-phase)
//   mem_addr_o    program memory write address
//   data_in_o     program memory write data
//   mem_we_o      one-cycle program memory write enable
//   loading_o     session in progress; core must stall
//   load_done_o   session finished with a good checksum
//   load_err_o    session finished with a checksum mismatch
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic [DATA_W-1:0] byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] data_in_o,
  output logic              mem_we_o,
  output logic              loading_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  typedef enum logic [2:0] {
    StIdle, StWaitLen, StPayload, StAckLow, StCheck, StDone, StError
  } state_e;

  state_e state_q, state_d;
  state_e ret_q, ret_d;  // state to enter once the host drops valid

  logic              sync1_q, vs_q;
  logic              ack_q, ack_d;
  logic              we_q, we_d;
  logic              loading_q, loading_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              last_byte;

  // addr_q counts bytes already written; LEN=0 makes count-1 wrap to the top address.
  assign last_byte = (addr_q == count_q - ADDR_W'(1));

  // State register and datapath flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ret_q     <= StPayload;
      sync1_q   <= 1'b0;
      vs_q      <= 1'b0;
      ack_q     <= 1'b0;
      we_q      <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      count_q   <= '0;
      data_q    <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      sync1_q   <= byte_valid_i;
      vs_q      <= sync1_q;
      ack_q     <= ack_d;
      we_q      <= we_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      chk_q     <= chk_d;
    end
  end

  // Next-state logic. load_start_i beats a coincident synchronized valid.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    if (load_start_i) begin
      state_d = StWaitLen;
      ret_d   = StPayload;
    end else begin
      case (state_q)
        StWaitLen: if (vs_q) begin
          state_d = StAckLow;
          ret_d   = StPayload;
        end
        StPayload: if (vs_q) begin
          state_d = StAckLow;
          ret_d   = last_byte ? StCheck : StPayload;
        end
        StAckLow: if (!vs_q) state_d = ret_q;
        StCheck: if (vs_q) begin
          state_d = StAckLow;
          ret_d   = (byte_in_i == chk_q) ? StDone : StError;
        end
        default: ;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin
    ack_d     = ack_q;
    we_d      = 1'b0;
    loading_d = loading_q;
    done_d    = done_q;
    err_d     = err_q;
    addr_d    = addr_q;
    count_d   = count_q;
    data_d    = data_q;
    chk_d     = chk_q;
    if (load_start_i) begin
      ack_d     = 1'b0;
      loading_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
      addr_d    = '0;
      chk_d     = '0;
    end else begin
      // Address advances the cycle after the write strobe.
      if (we_q) addr_d = addr_q + ADDR_W'(1);
      case (state_q)
        StWaitLen: if (vs_q) begin
          count_d = ADDR_W'(byte_in_i);
          ack_d   = 1'b1;
        end
        StPayload: if (vs_q) begin
          data_d = byte_in_i;
          we_d   = 1'b1;
          chk_d  = chk_q ^ byte_in_i;
          ack_d  = 1'b1;
        end
        StAckLow: if (!vs_q) begin
          ack_d = 1'b0;
          if (ret_q == StDone) begin
            loading_d = 1'b0;
            done_d    = 1'b1;
          end else if (ret_q == StError) begin
            loading_d = 1'b0;
            err_d     = 1'b1;
          end
        end
        StCheck: if (vs_q) ack_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign byte_ack_o  = ack_q;
  assign mem_addr_o  = addr_q;
  assign data_in_o   = data_q;
  assign mem_we_o    = we_q;
  assign loading_o   = loading_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;

endmodule
